// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the multi-channel PWM peripheral.
package pwm_pkg;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // Channel-index width: ceil(log2(n)) but never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler, up or up/down counter, direction and latched mode.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int unsigned RES     = 8,
    parameter int unsigned PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               mode,
    input  logic [PRESC_W-1:0] presc,
    output logic [RES-1:0]     cnt,
    output logic               tick_c,
    output logic               wrap_c,
    output logic               period_start
);

    localparam logic [RES-1:0] MAX = {RES{1'b1}};

    logic [PRESC_W-1:0] presc_cnt;
    dir_t               dir;
    logic               mode_q;

    assign tick_c = en && (presc_cnt == presc);

    // Last counter state of a period; the next tick returns to (0, up).
    assign wrap_c = (mode_q == MODE_CENTER) ? ((cnt == '0) && (dir == DIR_DOWN))
                                            : (cnt == MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_cnt    <= '0;
            cnt          <= '0;
            dir          <= DIR_UP;
            mode_q       <= MODE_EDGE;
            period_start <= 1'b0;
        end else if (!en) begin
            presc_cnt    <= '0;
            cnt          <= '0;
            dir          <= DIR_UP;
            mode_q       <= mode;
            period_start <= 1'b0;
        end else begin
            period_start <= tick_c && wrap_c;
            // A shrinking prescale value that lands below presc_cnt wraps without a tick.
            presc_cnt    <= (presc_cnt >= presc) ? '0 : presc_cnt + 1'b1;
            if (tick_c) begin
                if (wrap_c) begin
                    cnt    <= '0;
                    dir    <= DIR_UP;
                    mode_q <= mode;
                end else if (mode_q == MODE_EDGE) begin
                    cnt <= cnt + 1'b1;
                end else if (dir == DIR_UP) begin
                    if (cnt == MAX) begin
                        dir <= DIR_DOWN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pwm_multi_channel.sv
// NUM_CH PWM outputs on one timebase with double-buffered per-channel duty registers.
module pwm_multi_channel
    import pwm_pkg::*;
#(
    parameter  int unsigned NUM_CH  = 8,
    parameter  int unsigned RES     = 8,
    parameter  int unsigned PRESC_W = 8,
    localparam int unsigned CH_W    = idx_width(NUM_CH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_i,
    input  logic               mode_i,
    input  logic [PRESC_W-1:0] presc_i,
    input  logic [NUM_CH-1:0]  ch_en_i,
    input  logic               wr_en_i,
    input  logic [CH_W-1:0]    wr_ch_i,
    input  logic [RES-1:0]     wr_duty_i,
    output logic [NUM_CH-1:0]  pwm_o,
    output logic               period_start_o
);

    localparam logic [RES-1:0] MAX = {RES{1'b1}};

    logic [RES-1:0] cnt;
    logic           tick_c;
    logic           wrap_c;
    logic           load_c;
    logic [RES-1:0] shadow [NUM_CH];
    logic [RES-1:0] active [NUM_CH];

    pwm_timebase #(
        .RES     (RES),
        .PRESC_W (PRESC_W)
    ) u_timebase (
        .clk          (clk),
        .rst          (rst),
        .en           (en_i),
        .mode         (mode_i),
        .presc        (presc_i),
        .cnt          (cnt),
        .tick_c       (tick_c),
        .wrap_c       (wrap_c),
        .period_start (period_start_o)
    );

    // While disabled the active set tracks the shadows so re-enable starts with fresh duties.
    assign load_c = !en_i || (tick_c && wrap_c);

    // The load reads the pre-edge shadow, so a coincident write lands one period later.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (load_c) begin
                    active[i] <= shadow[i];
                end
                if (wr_en_i && (wr_ch_i == CH_W'(i))) begin
                    shadow[i] <= wr_duty_i;
                end
            end
        end
    end

    // Duty MAX is forced fully on; duty 0 never satisfies cnt < 0.
    always_comb begin
        pwm_o = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pwm_o[i] = en_i && ch_en_i[i] && ((active[i] == MAX) || (cnt < active[i]));
        end
    end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Scoreboarded bench for pwm_multi_channel against a period-position reference model.
module tb_pwm_multi_channel;

    localparam int NC  = 6;
    localparam int RS  = 8;
    localparam int PW  = 8;
    localparam int M   = (1 << RS) - 1;

    logic          clk;
    logic          rst;
    logic          en_i;
    logic          mode_i;
    logic [PW-1:0] presc_i;
    logic [NC-1:0] ch_en_i;
    logic          wr_en_i;
    logic [2:0]    wr_ch_i;
    logic [RS-1:0] wr_duty_i;
    logic [NC-1:0] pwm_o;
    logic          period_start_o;

    pwm_multi_channel #(
        .NUM_CH  (NC),
        .RES     (RS),
        .PRESC_W (PW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .en_i           (en_i),
        .mode_i         (mode_i),
        .presc_i        (presc_i),
        .ch_en_i        (ch_en_i),
        .wr_en_i        (wr_en_i),
        .wr_ch_i        (wr_ch_i),
        .wr_duty_i      (wr_duty_i),
        .pwm_o          (pwm_o),
        .period_start_o (period_start_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [NC-1:0] pwm;
        logic          ps;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: position within the current period, counted in ticks.
    int m_pc;
    int m_ph;
    bit m_mode;
    bit m_ps;
    int m_sh  [NC];
    int m_act [NC];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clock();
        bit tick;
        int per;
        if (rst) begin
            m_pc = 0; m_ph = 0; m_mode = 0; m_ps = 0;
            for (int i = 0; i < NC; i++) begin m_sh[i] = 0; m_act[i] = 0; end
            return;
        end
        if (!en_i) begin
            m_pc = 0; m_ph = 0; m_mode = mode_i; m_ps = 0;
            for (int i = 0; i < NC; i++) m_act[i] = m_sh[i];
        end else begin
            tick = (m_pc == int'(presc_i));
            per  = m_mode ? 2 * (M + 1) : (M + 1);
            m_ps = 0;
            m_pc = (m_pc >= int'(presc_i)) ? 0 : m_pc + 1;
            if (tick) begin
                m_ph++;
                if (m_ph == per) begin
                    m_ph = 0; m_ps = 1; m_mode = mode_i;
                    for (int i = 0; i < NC; i++) m_act[i] = m_sh[i];
                end
            end
        end
        if (wr_en_i && int'(wr_ch_i) < NC) m_sh[wr_ch_i] = int'(wr_duty_i);
    endtask

    function automatic logic [NC-1:0] model_pwm();
        logic [NC-1:0] p;
        int c;
        c = (m_mode && m_ph > M) ? (2 * M + 1 - m_ph) : m_ph;
        for (int i = 0; i < NC; i++)
            p[i] = en_i && ch_en_i[i] && (m_act[i] == M || c < m_act[i]);
        return p;
    endfunction

    // One clock: model advances on the edge, expectation queued, return at negedge.
    task automatic step();
        exp_t e;
        @(posedge clk);
        model_clock();
        #1;
        e.pwm = model_pwm();
        e.ps  = m_ps;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic wr(input int ch, input int d);
        wr_en_i = 1'b1; wr_ch_i = 3'(ch); wr_duty_i = 8'(d);
        step();
        wr_en_i = 1'b0;
    endtask

    task automatic wait_ps();
        int n;
        n = 0;
        step();
        while (!period_start_o && n < 3000) begin step(); n++; end
        check("wait_period_start", int'(period_start_o), 1);
    endtask

    task automatic count_period(input int chan, output int hi);
        hi = int'(pwm_o[chan]);
        for (int k = 1; k <= M; k++) begin step(); hi += int'(pwm_o[chan]); end
    endtask

    // Monitor: compares DUT against each queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_pwm_o", int'(pwm_o), int'(e.pwm));
                check("sb_period_start_o", int'(period_start_o), int'(e.ps));
            end
        end
    end

    initial begin
        int hi, hi1, hi2, ps, run, best, r, d, idx;
        int hc [NC];

        rst = 1'b1; en_i = 1'b1; mode_i = 1'b0; presc_i = '0; ch_en_i = '1;
        wr_en_i = 1'b0; wr_ch_i = '0; wr_duty_i = '0;
        repeat (3) begin
            step();
            check("reset_pwm", int'(pwm_o), 0);
            check("reset_ps", int'(period_start_o), 0);
        end
        rst = 1'b0;
        hi = 0; ps = 0;
        repeat (300) begin step(); hi += int'(|pwm_o); ps += int'(period_start_o); end
        check("idle_pwm_high", hi, 0);
        check("idle_ps_count", ps, 1);

        // Edge-aligned duties
        en_i = 1'b0;
        wr(0, 'h80); wr(1, 'hFF); wr(2, 'h00); wr(3, 'hFF); wr(4, 'h01); wr(5, 'hFE);
        step();
        en_i = 1'b1;
        hi = 0; hi1 = 0; hi2 = 0; ps = 0;
        repeat (512) begin
            step();
            hi += int'(pwm_o[0]); hi1 += int'(pwm_o[1]); hi2 += int'(pwm_o[2]);
            ps += int'(period_start_o);
        end
        check("edge_ch0_high", hi, 256);
        check("edge_ch1_high", hi1, 512);
        check("edge_ch2_high", hi2, 0);
        check("edge_ps_count", ps, 2);

        // Prescaler 3
        en_i = 1'b0; presc_i = 8'd3;
        wr(0, 'h40);
        step();
        en_i = 1'b1;
        hi = 0; ps = 0;
        repeat (2048) begin step(); hi += int'(pwm_o[0]); ps += int'(period_start_o); end
        check("presc_ch0_high", hi, 512);
        check("presc_ps_count", ps, 2);

        // Center-aligned
        en_i = 1'b0; presc_i = 8'd0; mode_i = 1'b1;
        wr(0, 'h10);
        step();
        en_i = 1'b1;
        hi = 0; ps = 0; run = 0; best = 0;
        repeat (1024) begin
            step();
            hi += int'(pwm_o[0]); ps += int'(period_start_o);
            run = pwm_o[0] ? run + 1 : 0;
            if (run > best) best = run;
        end
        check("center_ch0_high", hi, 64);
        check("center_longest_pulse", best, 32);
        check("center_ps_count", ps, 2);

        // Double buffering
        en_i = 1'b0; mode_i = 1'b0;
        wr(0, 'h80);
        step();
        en_i = 1'b1;
        wait_ps();
        hi = int'(pwm_o[0]);
        for (int k = 1; k <= M; k++) begin
            if (k == 100) begin wr_en_i = 1'b1; wr_ch_i = 3'd0; wr_duty_i = 8'h20; end
            else wr_en_i = 1'b0;
            step();
            hi += int'(pwm_o[0]);
        end
        wr_en_i = 1'b0;
        check("dbuf_current_period", hi, 128);
        step();
        check("dbuf_ps_b", int'(period_start_o), 1);
        count_period(0, hi);
        check("dbuf_next_period", hi, 32);
        wr(0, 'h60);
        check("dbuf_ps_c", int'(period_start_o), 1);
        count_period(0, hi);
        check("dbuf_coincident_write_period", hi, 32);
        step();
        count_period(0, hi);
        check("dbuf_after_coincident", hi, 96);

        // Out-of-range channel writes
        en_i = 1'b0;
        wr(6, 'hAA); wr(7, 'h55);
        step();
        en_i = 1'b1;
        for (int c = 0; c < NC; c++) hc[c] = 0;
        repeat (256) begin
            step();
            for (int c = 0; c < NC; c++) hc[c] += int'(pwm_o[c]);
        end
        check("bad_ch_ch0", hc[0], 96);
        check("bad_ch_ch1", hc[1], 256);
        check("bad_ch_ch2", hc[2], 0);
        check("bad_ch_ch3", hc[3], 256);
        check("bad_ch_ch4", hc[4], 1);
        check("bad_ch_ch5", hc[5], 254);

        // Per-channel disable is immediate
        ch_en_i[3] = 1'b0;
        #1;
        check("chen_drop_ch3", int'(pwm_o[3]), 0);
        check("chen_keep_ch1", int'(pwm_o[1]), 1);
        repeat (20) step();
        ch_en_i[3] = 1'b1;

        // Global disable mid-period, then restart
        wait_ps();
        repeat (100) step();
        en_i = 1'b0;
        hi = 0; ps = 0;
        repeat (5) begin step(); hi += int'(|pwm_o); ps += int'(period_start_o); end
        check("dis_pwm_high", hi, 0);
        check("dis_ps_count", ps, 0);
        en_i = 1'b1;
        ps = 0;
        repeat (M) begin step(); ps += int'(period_start_o); end
        check("reen_no_early_ps", ps, 0);
        step();
        check("reen_first_ps", int'(period_start_o), 1);

        // Randomized traffic against the model
        for (int n = 0; n < 6000; n++) begin
            r = int'($urandom_range(0, 999));
            wr_en_i = 1'b0;
            if (r < 100) begin
                wr_en_i = 1'b1;
                wr_ch_i = 3'($urandom_range(0, 7));
                case ($urandom_range(0, 3))
                    0:       d = 0;
                    1:       d = M;
                    default: d = int'($urandom_range(0, M));
                endcase
                wr_duty_i = 8'(d);
            end else if (r < 110) begin
                idx = int'($urandom_range(0, NC - 1));
                ch_en_i[idx] = ~ch_en_i[idx];
            end else if (r < 113) begin
                presc_i = 8'($urandom_range(0, 3));
            end else if (r < 116) begin
                mode_i = ~mode_i;
            end else if (r < 119) begin
                en_i = ~en_i;
            end else if (r == 999) begin
                rst = 1'b1;
            end
            step();
            rst = 1'b0;
        end
        wr_en_i = 1'b0;
        step();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
